alu_req_arbiter: RTL and testbench

- Shares one registered 16-bit ALU (ALU_16_bit: A, B, ALU_FUN in; ALU_OUT and five flags out, one-clock registered latency) among N_REQ requesters.
- Each requester sends an opcode and two operands over a valid/ready handshake. The block grants requesters round-robin, drives the ALU, captures the result and flags, and returns them over a per-requester response handshake.
- Sits between the ALU instance and its client blocks.
- Counts completed operations for debug.

---
 rtl/alu_ctrl_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 37 +++
 rtl/alu_req_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_req_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared constants for the ALU request arbiter.
//   - ALU opcode encodings (ADD=0 .. SHL=14, RSVD=15)
//   - arbiter FSM state encodings
//   - flag bit positions within the 5-bit flag vector
package alu_ctrl_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_MUL    = 4'd2;
  localparam logic [3:0] OP_DIV    = 4'd3;
  localparam logic [3:0] OP_AND    = 4'd4;
  localparam logic [3:0] OP_OR     = 4'd5;
  localparam logic [3:0] OP_NAND   = 4'd6;
  localparam logic [3:0] OP_NOR    = 4'd7;
  localparam logic [3:0] OP_XOR    = 4'd8;
  localparam logic [3:0] OP_XNOR   = 4'd9;
  localparam logic [3:0] OP_CMP_EQ = 4'd10;
  localparam logic [3:0] OP_CMP_GT = 4'd11;
  localparam logic [3:0] OP_CMP_LT = 4'd12;
  localparam logic [3:0] OP_SHR    = 4'd13;
  localparam logic [3:0] OP_SHL    = 4'd14;
  localparam logic [3:0] OP_RSVD   = 4'd15;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  localparam int FLAG_W     = 5;
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ARITH = 1;
  localparam int FLAG_LOGIC = 2;
  localparam int FLAG_CMP   = 3;
  localparam int FLAG_SHIFT = 4;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req   [N-1:0]   request vector
//   ptr   [IDW-1:0] highest-priority index this cycle
//   en              when low, no grant is produced
//   grant [N-1:0]   one-hot grant (zero if none)
//   gid   [IDW-1:0] binary index of the granted bit (0 if none)
module rr_arbiter #(
  parameter int N   = 2,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] gid
);

  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    gid   = '0;
    found = 1'b0;
    idx   = 0;
    // Walk upward from ptr, wrapping at N; first set bit wins.
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gid        = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one registered ALU among N_REQ requesters.
//   Requests (req_valid/req_ready, req_fun/req_a/req_b) are granted
//   round-robin in IDLE, issued to the ALU (alu_a/alu_b/alu_fun), the
//   one-cycle-late result (alu_out/alu_flags) is captured and returned on
//   rsp_valid/rsp_ready with rsp_out/rsp_flags/rsp_err. ops_done counts
//   completed responses (wraps).
// Build option: ALU_ILLEGAL_CHK_EN -- when defined, opcode 4'b1111 is
//   answered directly with rsp_err=1 and zero result, bypassing the ALU.
module alu_req_arbiter #(
  parameter int WIDTH = 16,
  parameter int FUN_W = 4,
  parameter int N_REQ = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*FUN_W-1:0] req_fun,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]       rsp_out,
  output logic [4:0]             rsp_flags,
  output logic                   rsp_err,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [FUN_W-1:0]       alu_fun,
  input  logic [WIDTH-1:0]       alu_out,
  input  logic [4:0]             alu_flags,
  output logic [15:0]            ops_done
);
  import alu_ctrl_pkg::*;

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef ALU_ILLEGAL_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic [1:0]       state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id_p0;
  logic             err_p0;
  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   gid;
  logic             any_grant;
  logic [FUN_W-1:0] win_fun;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic             illegal;
  logic             rsp_fire;

  rr_arbiter #(.N(N_REQ), .IDW(IDW)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    ((state == ST_IDLE) && !rst),
    .grant (grant),
    .gid   (gid)
  );

  assign any_grant = |grant;
  assign req_ready = grant;

  assign win_fun = req_fun[int'(gid)*FUN_W +: FUN_W];
  assign win_a   = req_a[int'(gid)*WIDTH +: WIDTH];
  assign win_b   = req_b[int'(gid)*WIDTH +: WIDTH];

  assign illegal  = CHK_EN && (win_fun == FUN_W'(OP_RSVD));
  assign rsp_fire = (state == ST_RESP) && rsp_ready[id_p0];

  assign rsp_valid = (state == ST_RESP) ? (N_REQ'(1) << id_p0) : '0;
  assign rsp_err   = CHK_EN ? err_p0 : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      id_p0     <= '0;
      err_p0    <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fun   <= '0;
      rsp_out   <= '0;
      rsp_flags <= '0;
      ops_done  <= '0;
    end else begin
      case (state)
        // Grant: latch the winner's request toward the ALU.
        ST_IDLE: begin
          if (any_grant) begin
            id_p0  <= gid;
            rr_ptr <= (gid == IDW'(N_REQ - 1)) ? '0 : gid + 1'b1;
            if (illegal) begin
              // Answer locally; the ALU inputs keep their previous values.
              rsp_out   <= '0;
              rsp_flags <= '0;
              err_p0    <= 1'b1;
              state     <= ST_RESP;
            end else begin
              alu_a   <= win_a;
              alu_b   <= win_b;
              alu_fun <= win_fun;
              err_p0  <= 1'b0;
              state   <= ST_ISSUE;
            end
          end
        end
        // ALU registers its result at the end of this cycle.
        ST_ISSUE: state <= ST_CAPTURE;
        // Capture the ALU result into the response registers.
        ST_CAPTURE: begin
          rsp_out   <= alu_out;
          rsp_flags <= alu_flags;
          state     <= ST_RESP;
        end
        // Hold the response until the owning requester takes it.
        ST_RESP: begin
          if (rsp_fire) begin
            ops_done <= ops_done + 16'd1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Testbench for alu_req_arbiter: directed requests with hand-computed
// expected responses pushed into a scoreboard queue; a monitor on the
// falling edge checks each response, its latency, and hold behaviour.
// Includes a behavioural registered ALU driving alu_out/alu_flags.
module tb_alu_req_arbiter;

  localparam int WIDTH = 16;
  localparam int FUN_W = 4;
  localparam int N_REQ = 2;

`ifdef ALU_ILLEGAL_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*FUN_W-1:0] req_fun;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]       rsp_out;
  logic [4:0]             rsp_flags;
  logic                   rsp_err;
  logic [WIDTH-1:0]       alu_a;
  logic [WIDTH-1:0]       alu_b;
  logic [FUN_W-1:0]       alu_fun;
  logic [WIDTH-1:0]       alu_out = '0;
  logic [4:0]             alu_flags = '0;
  logic [15:0]            ops_done;

  alu_req_arbiter #(.WIDTH(WIDTH), .FUN_W(FUN_W), .N_REQ(N_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_fun   (req_fun),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_flags (rsp_flags),
    .rsp_err   (rsp_err),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_fun   (alu_fun),
    .alu_out   (alu_out),
    .alu_flags (alu_flags),
    .ops_done  (ops_done)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: one-clock registered result, flags {Shift,CMP,Logic,Arith,Carry}.
  function automatic logic [20:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] f);
    logic [16:0] s;
    logic [15:0] r;
    logic [4:0]  fl;
    r = '0; fl = '0; s = '0;
    case (f)
      4'd0:  begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; fl = {3'b000, 1'b1, s[16]}; end
      4'd1:  begin r = a - b; fl = 5'b00010; end
      4'd2:  begin r = a * b; fl = 5'b00010; end
      4'd3:  begin r = (b == 16'd0) ? 16'd0 : a / b; fl = 5'b00010; end
      4'd4:  begin r = a & b; fl = 5'b00100; end
      4'd5:  begin r = a | b; fl = 5'b00100; end
      4'd6:  begin r = ~(a & b); fl = 5'b00100; end
      4'd7:  begin r = ~(a | b); fl = 5'b00100; end
      4'd8:  begin r = a ^ b; fl = 5'b00100; end
      4'd9:  begin r = ~(a ^ b); fl = 5'b00100; end
      4'd10: begin r = {15'd0, a == b}; fl = 5'b01000; end
      4'd11: begin r = {15'd0, a > b}; fl = 5'b01000; end
      4'd12: begin r = {15'd0, a < b}; fl = 5'b01000; end
      4'd13: begin r = a >> 1; fl = 5'b10000; end
      4'd14: begin r = a << 1; fl = 5'b10000; end
      default: begin r = '0; fl = '0; end
    endcase
    return {fl, r};
  endfunction

  always @(posedge clk) {alu_flags, alu_out} <= alu_model(alu_a, alu_b, alu_fun);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [15:0] out;
    logic [4:0]  flags;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   checks = 0;
  int   failures = 0;
  int   resp_cnt = 0;
  int   rsp_cycles = 0;
  int   twohot = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: acceptances, response checks, hold stability.
  logic             held = 1'b0;
  logic [15:0]      hold_out;
  logic [4:0]       hold_flags;
  logic [N_REQ-1:0] hold_vec;

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
      acc_q.delete();
    end else begin
      if ((req_ready & (req_ready - 1'b1)) != '0) twohot++;
      if ((req_valid & req_ready) != '0) acc_q.push_back(cyc);
      if (rsp_valid != '0) begin
        rsp_cycles++;
        if (!held) begin
          exp_t e;
          int   c0;
          held = 1'b1;
          hold_out = rsp_out;
          hold_flags = rsp_flags;
          hold_vec = rsp_valid;
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_valid_id", 32'(rsp_valid), 32'(N_REQ'(1) << e.id));
            chk("rsp_out", 32'(rsp_out), 32'(e.out));
            chk("rsp_flags", 32'(rsp_flags), 32'(e.flags));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            c0 = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
            chk("latency", 32'(cyc - c0), 32'(e.lat));
          end
        end else begin
          chk("hold_valid", 32'(rsp_valid), 32'(hold_vec));
          chk("hold_out", 32'(rsp_out), 32'(hold_out));
          chk("hold_flags", 32'(rsp_flags), 32'(hold_flags));
          chk("req_ready_in_resp", 32'(req_ready), 32'd0);
        end
        if ((rsp_valid & rsp_ready) != '0) begin
          held = 1'b0;
          resp_cnt++;
        end
      end
    end
  end

  task automatic push(input int id, input logic [15:0] o, input logic [4:0] fl,
                      input logic er, input int lat);
    exp_t e;
    e.id = id; e.out = o; e.flags = fl; e.err = er; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int id, input logic [3:0] f, input logic [15:0] a,
                         input logic [15:0] b);
    req_fun[id*FUN_W +: FUN_W] = f;
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_accept(input int id);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    if (!got) chk("accept_timeout", 32'(id), 32'hFFFF_FFFF);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    for (int i = 0; i < 40 && resp_cnt < target; i++) @(negedge clk);
    if (resp_cnt < target) chk("resp_timeout", 32'(resp_cnt), 32'(target));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int seen;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = '0;
    req_fun = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state, with requests pending to show req_ready stays low.
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_out", 32'(rsp_out), 32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_ops_done", 32'(ops_done), 32'd0);
    req_valid = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // T1: ADD 8+4 from req0.
    rsp_ready = 2'b11;
    push(0, 16'd12, 5'b00010, 1'b0, 3);
    set_req(0, 4'd0, 16'd8, 16'd4);
    wait_accept(0);
    wait_resp(1);
    chk("t1_ops_done", 32'(ops_done), 32'd1);

    // T2: both valid after reset; req0 MUL first, then req1 SUB.
    do_reset();
    push(0, 16'd32, 5'b00010, 1'b0, 3);
    push(1, 16'd4, 5'b00010, 1'b0, 3);
    set_req(0, 4'd2, 16'd8, 16'd4);
    set_req(1, 4'd1, 16'd8, 16'd4);
    wait_accept(0);
    wait_accept(1);
    wait_resp(3);
    chk("t2_ops_done", 32'(ops_done), 32'd2);

    // T3: back-pressure on req1 AND 8&4 while req0 waits with ADD 1+1.
    rsp_ready = 2'b01;
    push(1, 16'd0, 5'b00100, 1'b0, 3);
    set_req(1, 4'd4, 16'd8, 16'd4);
    wait_accept(1);
    push(0, 16'd2, 5'b00010, 1'b0, 3);
    set_req(0, 4'd0, 16'd1, 16'd1);
    for (int i = 0; i < 20 && !rsp_valid[1]; i++) @(negedge clk);
    chk("t3_rsp_valid1", 32'(rsp_valid), 32'd2);
    repeat (5) @(posedge clk);
    #1 rsp_ready = 2'b11;
    @(posedge clk);
    #1;
    chk("t3_done_valid", 32'(rsp_valid), 32'd0);
    chk("t3_ops_done", 32'(ops_done), 32'd3);
    wait_accept(0);
    wait_resp(5);
    chk("t3b_ops_done", 32'(ops_done), 32'd4);

    // T4: reset during CAPTURE of DIV 8/4 discards the operation.
    set_req(0, 4'd3, 16'd8, 16'd4);
    wait_accept(0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t4_rsp_out", 32'(rsp_out), 32'd0);
    chk("t4_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("t4_alu_fun", 32'(alu_fun), 32'd0);
    chk("t4_alu_a", 32'(alu_a), 32'd0);
    chk("t4_alu_b", 32'(alu_b), 32'd0);
    chk("t4_ops_done", 32'(ops_done), 32'd0);
    rst = 1'b0;
    seen = rsp_cycles;
    repeat (10) @(posedge clk);
    #1;
    chk("t4_no_rsp", 32'(rsp_cycles), 32'(seen));

    // T5: divide by zero.
    push(0, 16'd0, 5'b00010, 1'b0, 3);
    set_req(0, 4'd3, 16'd8, 16'd0);
    wait_accept(0);
    wait_resp(6);
    chk("t5_ops_done", 32'(ops_done), 32'd1);

    // T6: opcode 4'b1111.
    push(1, 16'd0, 5'b00000, CHK, CHK ? 1 : 3);
    set_req(1, 4'd15, 16'd8, 16'd4);
    wait_accept(1);
    chk("t6_alu_fun", 32'(alu_fun), CHK ? 32'd3 : 32'd15);
    wait_resp(7);
    chk("t6_ops_done", 32'(ops_done), 32'd2);

    chk("twohot_ready", 32'(twohot), 32'd0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
